inst_cache: RTL

Direct-mapped, read-only instruction cache between the instruction fetch queue and the backing memory port.
- Upstream: accepts fetch requests on the fetch queue's memory-request handshake and returns word-aligned instructions with their address.
- Downstream: refills whole lines from backing memory, one word per transaction.
- Hits return one cycle after acceptance and sustain one request per cycle.

---
 rtl/inst_cache_pkg.sv | 31 +++
 rtl/inst_cache_array.sv | 41 ++++
 rtl/inst_cache.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// The optional statistics counters are enabled by INST_CACHE_STATS_EN.
package inst_cache_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned DEF_NUM_LINES  = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOOKUP      = 3'd1,
        REFILL_REQ  = 3'd2,
        REFILL_WAIT = 3'd3,
        RESPOND     = 3'd4
    } cache_state_e;

    // Tag width left over after word, offset and index bits are removed
    function automatic int unsigned tag_width(input int unsigned num_lines,
                                              input int unsigned line_words);
        return 32'd30 - $clog2(line_words) - $clog2(num_lines);
    endfunction

    localparam int unsigned DEF_TAG_W = tag_width(DEF_NUM_LINES, DEF_LINE_WORDS);

    typedef struct packed {
        logic                                    valid;
        logic [DEF_TAG_W-1:0]                    tag;
        logic [DEF_LINE_WORDS-1:0][WORD_W-1:0]   data;
    } cache_line_t;

endpackage

// File: rtl/inst_cache_array.sv
// Single-port tag + data storage with registered read and per-word write enables.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned IDX_W      = $clog2(DEF_NUM_LINES),
    parameter int unsigned TAG_W      = DEF_TAG_W
)
(
    input  logic                               clk,
    input  logic [IDX_W-1:0]                   idx,
    input  logic                               rd_en,
    input  logic                               tag_we,
    input  logic [TAG_W-1:0]                   tag_wdata,
    input  logic [LINE_WORDS-1:0]              word_we,
    input  logic [WORD_W-1:0]                  word_wdata,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic [LINE_WORDS-1:0][WORD_W-1:0]  rd_data
);

    logic [TAG_W-1:0]                   tag_mem_r  [NUM_LINES];
    logic [LINE_WORDS-1:0][WORD_W-1:0]  data_mem_r [NUM_LINES];

    // Storage writes plus registered read port sharing one address
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem_r[idx] <= tag_wdata;
        end
        for (int w = 0; w < int'(LINE_WORDS); w++) begin
            if (word_we[w]) begin
                data_mem_r[idx][w] <= word_wdata;
            end
        end
        if (rd_en) begin
            rd_tag  <= tag_mem_r[idx];
            rd_data <= data_mem_r[idx];
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-at-a-time line refill.
// Define INST_CACHE_STATS_EN to build the hit/miss counters.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_inst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_addr,
    input  logic [31:0] mem_resp_inst,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
);

    localparam int unsigned OFS_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = tag_width(NUM_LINES, LINE_WORDS);
    localparam int unsigned CNT_W = (OFS_W == 0) ? 1 : OFS_W;

    cache_state_e                      state_r, state_n;
    logic [31:0]                       addr_r, req_word_addr_s, line_base_s, refill_addr_s;
    logic [CNT_W-1:0]                  cnt_r, lat_ofs_s;
    logic [IDX_W-1:0]                  req_idx_s, lat_idx_s, arr_idx_s;
    logic [TAG_W-1:0]                  lat_tag_s, rd_tag_s;
    logic [LINE_WORDS-1:0][WORD_W-1:0] rd_data_s;
    logic [LINE_WORDS-1:0]             word_we_s;
    logic [NUM_LINES-1:0]              valid_r;
    logic [31:0]                       crit_r, resp_inst_s;
    logic                              drop_r, flushed_r;
    logic                              hit_s, accept_s, wr_s, last_s, refilling_s;
    logic                              req_ready_s, resp_valid_s, mem_req_valid_s;

    assign req_word_addr_s = req_addr & 32'hFFFF_FFFC;
    assign req_idx_s       = IDX_W'(req_word_addr_s >> (2 + OFS_W));
    assign lat_idx_s       = IDX_W'(addr_r >> (2 + OFS_W));
    assign lat_tag_s       = TAG_W'(addr_r >> (2 + OFS_W + IDX_W));
    assign lat_ofs_s       = (OFS_W == 0) ? '0 : CNT_W'(addr_r >> 2);
    assign line_base_s     = addr_r & ~((32'd1 << (2 + OFS_W)) - 32'd1);
    assign refill_addr_s   = line_base_s | (32'(cnt_r) << 2);

    // During refill the array is addressed by the latched line, otherwise by the incoming request
    assign refilling_s = (state_r == REFILL_REQ) || (state_r == REFILL_WAIT);
    assign arr_idx_s   = refilling_s ? lat_idx_s : req_idx_s;
    assign hit_s       = valid_r[lat_idx_s] && (rd_tag_s == lat_tag_s);
    assign accept_s    = req_valid && req_ready_s && !reset;
    assign wr_s        = (state_r == REFILL_WAIT) && mem_resp_valid && (mem_resp_addr == refill_addr_s);
    assign last_s      = (32'(cnt_r) == (LINE_WORDS - 32'd1));
    assign word_we_s   = wr_s ? (LINE_WORDS'(1'b1) << cnt_r) : '0;

    inst_cache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .idx        (arr_idx_s),
        .rd_en      (accept_s),
        .tag_we     (wr_s && last_s),
        .tag_wdata  (lat_tag_s),
        .word_we    (word_we_s),
        .word_wdata (mem_resp_inst),
        .rd_tag     (rd_tag_s),
        .rd_data    (rd_data_s)
    );

    // Next-state and handshake decode
    always_comb begin
        state_n         = state_r;
        req_ready_s     = 1'b0;
        resp_valid_s    = 1'b0;
        resp_inst_s     = 32'd0;
        mem_req_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = !kill;
                if (req_valid && !kill) begin
                    state_n = LOOKUP;
                end else begin
                    state_n = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    resp_valid_s = !kill;
                    resp_inst_s  = rd_data_s[lat_ofs_s];
                    req_ready_s  = !kill;
                    if (req_valid && !kill) begin
                        state_n = LOOKUP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    state_n = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid_s = 1'b1;
                if (mem_req_ready) begin
                    state_n = REFILL_WAIT;
                end else begin
                    state_n = REFILL_REQ;
                end
            end
            REFILL_WAIT: begin
                if (wr_s) begin
                    state_n = last_s ? RESPOND : REFILL_REQ;
                end else begin
                    state_n = REFILL_WAIT;
                end
            end
            RESPOND: begin
                resp_valid_s = !drop_r && !kill;
                resp_inst_s  = crit_r;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, request latch, refill bookkeeping and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 32'd0;
            cnt_r     <= '0;
            drop_r    <= 1'b0;
            flushed_r <= 1'b0;
            crit_r    <= 32'd0;
            valid_r   <= '0;
        end else begin
            state_r <= state_n;
            if (accept_s) begin
                addr_r <= req_word_addr_s;
                drop_r <= 1'b0;
            end else if (kill && (state_r != IDLE)) begin
                drop_r <= 1'b1;
            end
            // A flush seen mid-refill keeps the new line from being marked valid
            if ((state_r == LOOKUP) && !hit_s) begin
                cnt_r     <= '0;
                flushed_r <= 1'b0;
            end else begin
                if (wr_s) begin
                    cnt_r <= cnt_r + 1'b1;
                end
                if (flush) begin
                    flushed_r <= 1'b1;
                end
            end
            if (wr_s && (cnt_r == lat_ofs_s)) begin
                crit_r <= mem_resp_inst;
            end
            if (flush) begin
                valid_r <= '0;
            end else if (wr_s && last_s && !flushed_r) begin
                valid_r[lat_idx_s] <= 1'b1;
            end
        end
    end

    assign req_ready     = req_ready_s && !reset;
    assign resp_valid    = resp_valid_s && !reset;
    assign resp_addr     = resp_valid ? addr_r : 32'd0;
    assign resp_inst     = resp_valid ? resp_inst_s : 32'd0;
    assign mem_req_valid = mem_req_valid_s && !reset;
    assign mem_req_addr  = mem_req_valid ? refill_addr_s : 32'd0;

`ifdef INST_CACHE_STATS_EN
    logic [31:0] hits_r, misses_r;

    // Lookup outcome counters, counted even when the response is killed
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else if (state_r == LOOKUP) begin
            if (hit_s) begin
                hits_r <= hits_r + 32'd1;
            end else begin
                misses_r <= misses_r + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_r;
    assign stat_misses = misses_r;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule
